// File: rtl/vert_ucode_quicksort_pkg.sv
// Shared types and constants for the microcoded quicksort.
// The enqueue front-end and its round-robin bank picker use them.
package vert_ucode_quicksort_pkg;

    localparam int N      = 16;
    localparam int W      = 32;
    localparam int BANK_N = 2;

    typedef logic [$clog2(BANK_N)-1:0] bank_n_t;
    typedef logic [$clog2(N)-1:0]      addr_t;
    typedef logic [$clog2(N):0]        n_t;
    typedef logic [W-1:0]              w_t;

    typedef enum logic [2:0] {
        ENQUEUE_FSM_IDLE = 3'b000,
        ENQUEUE_FSM_LOAD = 3'b101
    } enqueue_fsm_t;

    localparam int ENQUEUE_FSM_BUSY_B = 2;

    typedef struct packed {
        bank_n_t bank;
        n_t      n;
        logic    error;
    } load_done_t;

    // Round-robin successor of a bank index, wrapping at BANK_N.
    function automatic bank_n_t bank_inc(input bank_n_t b);
        return (b == bank_n_t'(BANK_N - 1)) ? '0 : bank_n_t'(b + 1'b1);
    endfunction

endpackage

// File: rtl/vert_ucode_quicksort_bank_pick.sv
// Combinational round-robin picker.
// Returns the first idle bank at or after the rr pointer.
module vert_ucode_quicksort_bank_pick
    import vert_ucode_quicksort_pkg::*;
(
    input  logic [BANK_N-1:0]         bank_idle,
    input  logic [$clog2(BANK_N)-1:0] rr,
    output logic                      found,
    output logic [$clog2(BANK_N)-1:0] bank
);

    // Scan from the farthest offset down so the nearest idle bank wins.
    always_comb begin
        bank_n_t idx;
        found = 1'b0;
        bank  = '0;
        idx   = '0;
        for (int i = BANK_N - 1; i >= 0; i--) begin
            idx = bank_n_t'((int'(rr) + i) % BANK_N);
            if (bank_idle[idx]) begin
                found = 1'b1;
                bank  = idx;
            end
        end
    end

endmodule

// File: rtl/vert_ucode_quicksort_enqueue.sv
// Quicksort input front-end: streams an unsorted list into an idle bank RAM
// and reports load start and completion to the bank-state holder.
module vert_ucode_quicksort_enqueue
    import vert_ucode_quicksort_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    input  logic [W-1:0]              in_w,
    input  logic                      in_commit,
    output logic                      in_rdy,
    input  logic [BANK_N-1:0]         bank_idle,
    output logic                      wr_en,
    output logic [$clog2(BANK_N)-1:0] wr_bank,
    output logic [$clog2(N)-1:0]      wr_addr,
    output logic [W-1:0]              wr_data,
    output logic                      load_start_vld,
    output logic                      load_done_vld,
    output logic [$clog2(N):0]        load_done_n,
    output logic                      load_done_error,
    output logic                      busy
);

    enqueue_fsm_t state;
    n_t           n;
    bank_n_t      rr;
    logic         pick_found;
    bank_n_t      pick_bank;
    logic         accept;
    logic         loading;
    bank_n_t      tgt_bank;
    n_t           cnt_next;
    logic         last;

    logic         vld_p1;
    bank_n_t      wr_bank_p1;
    addr_t        wr_addr_p1;
    w_t           wr_data_p1;
    logic         start_p1;
    logic         done_vld_p1;
    load_done_t   done_p1;

    vert_ucode_quicksort_bank_pick u_pick (
        .bank_idle (bank_idle),
        .rr        (rr),
        .found     (pick_found),
        .bank      (pick_bank)
    );

    assign loading = (state == ENQUEUE_FSM_LOAD);
    assign busy    = state[ENQUEUE_FSM_BUSY_B];

    // The done cycle doubles as a bubble so the holder can retire the bank
    // from bank_idle before the next pick is taken.
    assign in_rdy = ~rst & ~done_vld_p1 & (loading | pick_found);
    assign accept = in_vld & in_rdy;

    always_comb begin
        tgt_bank = loading ? wr_bank_p1 : pick_bank;
        cnt_next = loading ? n_t'(n + 1'b1) : n_t'(1);
        last     = in_commit | (cnt_next == n_t'(N));
    end

    // Stage p0 -> p1: accepted word becomes a RAM write one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ENQUEUE_FSM_IDLE;
            n           <= '0;
            rr          <= '0;
            vld_p1      <= 1'b0;
            start_p1    <= 1'b0;
            done_vld_p1 <= 1'b0;
            wr_bank_p1  <= '0;
            wr_addr_p1  <= '0;
            wr_data_p1  <= '0;
            done_p1     <= '0;
        end else begin
            vld_p1      <= accept;
            start_p1    <= accept & ~loading;
            done_vld_p1 <= accept & last;
            if (done_vld_p1) begin
                rr <= bank_inc(done_p1.bank);
            end
            if (accept) begin
                wr_bank_p1 <= tgt_bank;
                wr_addr_p1 <= loading ? addr_t'(n) : '0;
                wr_data_p1 <= in_w;
                n          <= cnt_next;
                if (last) begin
                    done_p1 <= '{bank: tgt_bank, n: cnt_next, error: ~in_commit};
                    state   <= ENQUEUE_FSM_IDLE;
                end else begin
                    state   <= ENQUEUE_FSM_LOAD;
                end
            end
        end
    end

    assign wr_en           = vld_p1;
    assign wr_bank         = wr_bank_p1;
    assign wr_addr         = wr_addr_p1;
    assign wr_data         = wr_data_p1;
    assign load_start_vld  = start_p1;
    assign load_done_vld   = done_vld_p1;
    assign load_done_n     = done_p1.n;
    assign load_done_error = done_vld_p1 & done_p1.error;

endmodule
